// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract engine.
package addsub_pkg;

  localparam int unsigned DIGIT_W = 2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Width of a counter that indexes n digits; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_addsub_slice.sv
// Combinational 2-bit add/subtract slice; subtract inverts b and relies on the
// caller to seed the carry with the inverted borrow.
module digit_addsub_slice
  import addsub_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               c_in,
  input  logic               op,
  output logic [DIGIT_W-1:0] s,
  output logic               c_out
);

  logic [DIGIT_W-1:0] b_eff;

  always_comb begin
    b_eff      = (op == OP_SUB) ? ~b : b;
    {c_out, s} = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, c_in};
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, one 2-bit digit per clock through a single slice.
// Optional signed-overflow flag enabled by DIGIT_SERIAL_ADDSUB_OVF_EN.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N_DIGITS = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned      CNT_W = cnt_width(N_DIGITS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_DIGITS - 1);

  if ((WIDTH < 2) || (WIDTH % 2 != 0) || (N_DIGITS != WIDTH / DIGIT_W)) begin : g_bad_cfg
    $error("digit_serial_addsub: WIDTH must be even and >= 2, N_DIGITS must equal WIDTH/2");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d, carry_q, carry_d, c_out_q, c_out_d;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [DIGIT_W-1:0] sum;
  logic               slice_c;
  logic               last_digit;

  digit_addsub_slice u_slice (
    .a    (a_sr_q[DIGIT_W-1:0]),
    .b    (b_sr_q[DIGIT_W-1:0]),
    .c_in (carry_q),
    .op   (op_q),
    .s    (sum),
    .c_out(slice_c)
  );

  assign last_digit = (state_q == RUN) && (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    carry_d     = carry_q;
    c_out_d     = c_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sr_d     = a;
          b_sr_d     = b;
          op_d       = op;
          carry_d    = (op == OP_SUB) ? ~c_in : c_in;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Digits enter at the top so the LSB digit lands at bit 0 after N_DIGITS shifts.
        a_sr_d  = a_sr_q >> DIGIT_W;
        b_sr_d  = b_sr_q >> DIGIT_W;
        res_d   = (res_q >> DIGIT_W) | (WIDTH'(sum) << (WIDTH - DIGIT_W));
        carry_d = slice_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_digit) begin
          c_out_d     = (op_q == OP_SUB) ? ~slice_c : slice_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      op_q        <= OP_ADD;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      c_out_q     <= c_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = res_q;
  assign c_out     = c_out_q;

`ifdef DIGIT_SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
  logic signs_differ;

  // On the last digit the shift registers hold the original operand sign bits.
  always_comb begin
    signs_differ = a_sr_q[DIGIT_W-1] ^ b_sr_q[DIGIT_W-1];
    ovf_d        = ovf_q;
    if (last_digit) begin
      ovf_d = ((op_q == OP_SUB) ? signs_differ : ~signs_differ) &&
              (sum[DIGIT_W-1] != a_sr_q[DIGIT_W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Randomised and directed bench for digit_serial_addsub at WIDTH 8, 2 and 16.
module tb_digit_serial_addsub;

`ifdef DIGIT_SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst8_n;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic reference: returns {ovf, c_out, s[15:0]}.
  function automatic logic [17:0] ref_model(input int unsigned w, input longint unsigned x,
                                            input longint unsigned y, input logic o, input logic ci);
    longint          d;
    longint unsigned m, sres;
    logic            co, xs, ys, ss, v;
    m = 64'd1 << w;
    if (o == 1'b0) begin
      d  = longint'(x + y + longint'(ci));
      co = (d >= longint'(m));
    end else begin
      d  = longint'(x) - longint'(y) - longint'(ci);
      co = (d < 0);
    end
    sres = unsigned'(d + longint'(m)) % m;
    xs   = x[w-1];
    ys   = y[w-1];
    ss   = sres[w-1];
    v    = o ? ((xs != ys) && (ss != xs)) : ((xs == ys) && (ss != xs));
    return {v & OVF_EN, co, sres[15:0]};
  endfunction

  // WIDTH = 8 instance for directed tests
  logic       in_valid8, in_ready8, op8, c8, out_valid8, out_ready8, co8, ovf8;
  logic [7:0] a8, b8, s8;

  digit_serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .c_in(c8), .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .c_out(co8), .ovf(ovf8)
  );

  task automatic run8(input logic o, input logic [7:0] x, input logic [7:0] y, input logic ci,
                      input logic [7:0] es, input logic eco, input logic eov, input int hold,
                      input string tag);
    int lat;
    check({tag, "/in_ready_idle"}, 64'(in_ready8), 64'(1));
    in_valid8 = 1'b1; op8 = o; a8 = x; b8 = y; c8 = ci;
    @(posedge clk); #1;
    in_valid8 = 1'b0; op8 = ~o; a8 = ~x; b8 = 8'($urandom); c8 = ~ci;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(4));
    check({tag, "/s"}, 64'(s8), 64'(es));
    check({tag, "/c_out"}, 64'(co8), 64'(eco));
    check({tag, "/ovf"}, 64'(ovf8), 64'(eov & OVF_EN));
    for (int i = 0; i < hold; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'($urandom);
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 64'(out_valid8), 64'(1));
      check({tag, "/hold_in_ready"}, 64'(in_ready8), 64'(0));
      check({tag, "/hold_s"}, 64'(s8), 64'(es));
      check({tag, "/hold_c_out"}, 64'(co8), 64'(eco));
      check({tag, "/hold_ovf"}, 64'(ovf8), 64'(eov & OVF_EN));
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check({tag, "/valid_drop"}, 64'(out_valid8), 64'(0));
    check({tag, "/in_ready_back"}, 64'(in_ready8), 64'(1));
  endtask

  // Random sweeps at WIDTH 2 and 16
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int unsigned W  = (g == 0) ? 2 : 16;
    localparam int unsigned ND = W / 2;
    logic         iv, ir, o, ci, ov, orr, co, vf;
    logic [W-1:0] x, y, sr;
    logic         sweep_done = 1'b0;

    digit_serial_addsub #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .op(o),
      .a(x), .b(y), .c_in(ci), .out_valid(vf), .out_ready(orr),
      .s(sr), .c_out(co), .ovf(ov)
    );

    initial begin
      logic [17:0]  r;
      logic [W-1:0] ra, rb;
      logic         rop, rc;
      int           lat;
      iv = 1'b0; orr = 1'b0; o = 1'b0; ci = 1'b0; x = '0; y = '0;
      @(posedge rst_n);
      @(posedge clk); #1;
      for (int n = 0; n < 1000; n++) begin
        ra = W'($urandom); rb = W'($urandom); rop = 1'($urandom); rc = 1'($urandom);
        check($sformatf("w%0d_in_ready", W), 64'(ir), 64'(1));
        iv = 1'b1; x = ra; y = rb; o = rop; ci = rc;
        @(posedge clk); #1;
        iv = 1'($urandom); x = W'($urandom); y = W'($urandom); o = ~rop; ci = ~rc;
        lat = 0;
        while (!vf && lat < int'(ND) + 8) begin
          @(posedge clk); #1;
          lat++;
        end
        iv = 1'b0;
        r = ref_model(W, 64'(ra), 64'(rb), rop, rc);
        check($sformatf("w%0d_latency", W), 64'(lat), 64'(ND));
        check($sformatf("w%0d_s", W), 64'(sr), 64'(r[W-1:0]));
        check($sformatf("w%0d_c_out", W), 64'(co), 64'(r[16]));
        check($sformatf("w%0d_ovf", W), 64'(ov), 64'(r[17]));
        repeat ($urandom_range(2)) @(posedge clk);
        #1;
        orr = 1'b1;
        @(posedge clk); #1;
        orr = 1'b0;
        check($sformatf("w%0d_valid_drop", W), 64'(vf), 64'(0));
      end
      sweep_done = 1'b1;
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0; rst8_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/in_ready", 64'(in_ready8), 64'(1));
    check("rst/out_valid", 64'(out_valid8), 64'(0));
    check("rst/s", 64'(s8), 64'(0));
    check("rst/c_out", 64'(co8), 64'(0));
    check("rst/ovf", 64'(ovf8), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; rst8_n = 1'b1;
    @(posedge clk); #1;

    run8(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, "add_5a_3c");
    run8(1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 0, "sub_10_20");
    run8(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, "sub_80_01");
    run8(1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0, "add_ff_00_c");
    run8(1'b1, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 0, "sub_05_05_c");
    run8(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 5, "backpressure");

    // Reset asserted during the second RUN cycle discards the operation.
    in_valid8 = 1'b1; op8 = 1'b0; a8 = 8'h77; b8 = 8'h11; c8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    rst8_n = 1'b0;
    #1;
    check("midrun_rst/in_ready", 64'(in_ready8), 64'(1));
    check("midrun_rst/out_valid", 64'(out_valid8), 64'(0));
    check("midrun_rst/s", 64'(s8), 64'(0));
    check("midrun_rst/c_out", 64'(co8), 64'(0));
    check("midrun_rst/ovf", 64'(ovf8), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("midrun_rst/no_pulse", 64'(out_valid8), 64'(0));
    @(negedge clk);
    rst8_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst/out_valid", 64'(out_valid8), 64'(0));
    run8(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, "after_rst_add");

    waited = 0;
    while (!(g_sweep[0].sweep_done && g_sweep[1].sweep_done) && waited < 60000) begin
      @(posedge clk);
      waited++;
    end
    check("sweeps_done", 64'(g_sweep[0].sweep_done & g_sweep[1].sweep_done), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
